// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the RV32I multicycle core: sequences fetch/decode/execute/mem/writeback
// and drives the Moore datapath selects, including the writeback result_src.
module multicycle_main_fsm #(
    parameter int USE_MEM_READY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       retire,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    // Same encoding as ResultSource_pkg::ResultSource_t in the writeback mux.
    typedef enum logic [1:0] {
        RESULT_FROM_ALU = 2'b00,
        RESULT_FROM_MEM = 2'b01,
        RESULT_FROM_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t      state, state_nxt;
    result_src_t res_sel;
    logic        mr;
    logic        pc_update, branch;
    logic        mem_write_c, ir_write_c, reg_write_c, retire_c, illegal_c;

    assign mr = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = S_FETCH;
        pc_update   = 1'b0;
        branch      = 1'b0;
        adr_src     = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        retire_c    = 1'b0;
        illegal_c   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        res_sel     = RESULT_FROM_ALU;
        unique case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                res_sel    = RESULT_FROM_PC4;
                ir_write_c = mr;
                pc_update  = mr;
                state_nxt  = mr ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut for BEQ.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECR;
                    OP_I:         state_nxt = S_EXECI;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_JAL:       state_nxt = S_JAL;
                    default: begin
                        illegal_c = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nxt = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src   = 1'b1;
                state_nxt = mr ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                res_sel     = RESULT_FROM_MEM;
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
                retire_c    = mr;
                state_nxt   = mr ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                retire_c  = 1'b1;
            end
            S_JAL: begin
                // PC <= ALUOut (target), ALU forms OldPC+4 for the ALUWB link write.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_nxt = S_ALUWB;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Enables are held low for as long as reset is asserted.
    assign pc_write      = rst_n & (pc_update | (branch & zero));
    assign mem_write     = rst_n & mem_write_c;
    assign ir_write      = rst_n & ir_write_c;
    assign reg_write     = rst_n & reg_write_c;
    assign retire        = rst_n & retire_c;
    assign illegal_instr = rst_n & illegal_c;
    assign result_src    = res_sel;
    assign state_dbg     = state;

endmodule
